// File: rtl/register_32_pkg.sv
// Shared constants for the PA-RISC register file storage.
// Each architectural register is one register_32 instance.
package register_32_pkg;

  localparam int          REG_WIDTH = 32;
  localparam logic [31:0] REG_RESET = 32'h0000_0000;

endpackage

// File: rtl/register_32_dff_le.sv
// Single-bit flop with synchronous load enable and async active-high clear.
// Clear takes priority over load.
module dff_le #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_le,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_q <= RST_VAL;
    end else if (i_le) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_32.sv
// WIDTH-bit storage register: one dff_le per bit, shared enable and clear.
// Q comes straight from the flops; only Clr reaches it without a clock.
module register_32
  import register_32_pkg::*;
#(
  parameter int               WIDTH       = REG_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             LE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] w_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_le #(
      .RST_VAL (RESET_VALUE[i])
    ) u_bit (
      .i_clk (Clk),
      .i_clr (Clr),
      .i_le  (LE),
      .i_d   (D[i]),
      .o_q   (w_q[i])
    );
  end

  assign Q = w_q;

endmodule

// File: tb/tb_register_32.sv
// Scoreboard bench for register_32: expected Q queued when driven,
// popped and compared after the edge (or after an async clear).
module tb_register_32;
  import register_32_pkg::*;

  localparam int W = REG_WIDTH;

  logic         Clk = 1'b0;
  logic         Clr;
  logic         LE;
  logic [W-1:0] D;
  logic [W-1:0] Q;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] r_model = REG_RESET;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 Clk = ~Clk;

  register_32 #(
    .WIDTH       (W),
    .RESET_VALUE (REG_RESET)
  ) dut (
    .Clk (Clk),
    .Clr (Clr),
    .LE  (LE),
    .D   (D),
    .Q   (Q)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got empty-queue want entry", tag);
    end else begin
      chk(tag, Q, exp_q.pop_front());
    end
  endtask

  task automatic step(input logic clr, input logic le,
                      input logic [W-1:0] d, input string tag);
    @(negedge Clk);
    Clr = clr;
    LE  = le;
    D   = d;
    #1;
    chk({tag, "/mid"}, Q, clr ? REG_RESET : r_model);
    if (clr)     r_model = REG_RESET;
    else if (le) r_model = d;
    exp_q.push_back(r_model);
    @(posedge Clk);
    #1;
    pop_chk(tag);
  endtask

  task automatic aclr();
    @(negedge Clk);
    #2;
    Clr = 1'b1;
    r_model = REG_RESET;
    exp_q.push_back(r_model);
    #1;
    pop_chk("aclr");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Clr = 1'b1;
    LE  = 1'b0;
    D   = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'hA5A5_A5A5, "pwrup");
    step(1'b0, 1'b1, 32'hDEAD_BEEF, "load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hCAFE_BABE, "hold");
    aclr();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'hCAFE_BABE, "clrhi");
    step(1'b0, 1'b1, 32'h1234_5678, "reload");
    step(1'b1, 1'b1, 32'hFFFF_FFFF, "prio");
    for (int i = 0; i < W; i++) begin
      logic [W-1:0] w_pat;
      w_pat = '0;
      w_pat[i] = 1'b1;
      step(1'b0, 1'b1, w_pat, "walk");
    end
    step(1'b0, 1'b0, 32'h0000_0000, "hold2");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
